// File: rtl/paddle_position_reader.sv
// Fetches paddle/ball positions from a DPRAM once per frame, clamps them to the
// screen, and publishes all entries together with a one-cycle posValid pulse.
module paddle_position_reader #(
   parameter logic [15:0] BASE_ADDRESS  = 16'd0,
   parameter int unsigned NUM_ENTRIES   = 3,
   parameter int unsigned RD_LATENCY    = 1,
   parameter logic [15:0] SCREEN_HEIGHT = 16'd480,
   parameter logic [15:0] PADDLE_HEIGHT = 16'd100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frameStart,
   output logic        rdEnable,
   output logic [15:0] rdAddr,
   input  logic [31:0] rdData,
   output logic [31:0] leftPaddle,
   output logic [31:0] rightPaddle,
   output logic [31:0] ballPos,
   output logic        posValid,
   output logic        busy,
   output logic [7:0]  missedFrames
);

   localparam int unsigned IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam int unsigned SHADOW_N   = (NUM_ENTRIES > 3) ? NUM_ENTRIES : 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
   localparam logic [1:0]  WAIT_LOAD  = 2'(RD_LATENCY - 1);
   localparam logic [15:0] PADDLE_MAX = SCREEN_HEIGHT - PADDLE_HEIGHT;
   localparam logic [15:0] BALL_MAX   = SCREEN_HEIGHT - 16'd1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CAPTURE,
      S_PUBLISH
   } state_e;

   function automatic logic [31:0] reset_pos(input int entry);
      case (entry)
         0:       return {16'h000F, 16'd190};
         1:       return {16'd615,  16'd190};
         2:       return {16'd320,  16'd240};
         default: return '0;
      endcase
   endfunction

   // Entries 0 and 1 are paddles (top edge limited so the paddle stays on
   // screen); everything else is treated as the ball.
   function automatic logic [31:0] clamp_entry(input logic [31:0] word, input int entry);
      logic [15:0] y_max;
      y_max = (entry < 2) ? PADDLE_MAX : BALL_MAX;
      return {word[31:16], (word[15:0] > y_max) ? y_max : word[15:0]};
   endfunction

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [1:0]        wait_q, wait_d;
   logic [15:0]       rd_addr_q, rd_addr_d;
   logic [7:0]        missed_q, missed_d;
   logic              armed_q;
   logic [31:0]       shadow_q [SHADOW_N];
   logic [31:0]       shadow_d [SHADOW_N];
   logic [31:0]       pub_q [3];
   logic [31:0]       pub_d [3];
   logic [15:0]       issue_addr;

   assign issue_addr = BASE_ADDRESS + 16'(idx_q);

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; otherwise always_comb would infer a latch.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wait_d    = wait_q;
      rd_addr_d = rd_addr_q;
      missed_d  = missed_q;
      shadow_d  = shadow_q;
      pub_d     = pub_q;

      case (state_q)
         S_IDLE: begin
            // armed_q masks a frameStart on the edge that releases reset.
            if (frameStart && armed_q) begin
               idx_d   = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            rd_addr_d = issue_addr;
            wait_d    = WAIT_LOAD;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            if (wait_q == 2'd0) state_d = S_CAPTURE;
            else                wait_d  = wait_q - 2'd1;
         end
         S_CAPTURE: begin
            for (int i = 0; i < int'(SHADOW_N); i++) begin
               if (int'(idx_q) == i) shadow_d[i] = clamp_entry(rdData, i);
            end
            if (idx_q == LAST_IDX) begin
               // Load the published set from next-state shadows so the outputs
               // already hold the new frame while posValid is high.
               for (int i = 0; i < 3; i++) pub_d[i] = shadow_d[i];
               state_d = S_PUBLISH;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_ISSUE;
            end
         end
         S_PUBLISH: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      if (frameStart && (state_q != S_IDLE) && (missed_q != 8'hFF)) begin
         missed_d = missed_q + 8'd1;
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         wait_q    <= '0;
         rd_addr_q <= BASE_ADDRESS;
         missed_q  <= '0;
         armed_q   <= 1'b0;
         // NOTE: the shadow and published arrays are reset explicitly because
         // they have defined power-on positions, unlike a plain data buffer.
         for (int i = 0; i < int'(SHADOW_N); i++) shadow_q[i] <= reset_pos(i);
         for (int i = 0; i < 3; i++) pub_q[i] <= reset_pos(i);
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wait_q    <= wait_d;
         rd_addr_q <= rd_addr_d;
         missed_q  <= missed_d;
         armed_q   <= 1'b1;
         shadow_q  <= shadow_d;
         pub_q     <= pub_d;
      end
   end

   assign rdEnable     = (state_q == S_ISSUE);
   assign rdAddr       = (state_q == S_ISSUE) ? issue_addr : rd_addr_q;
   assign posValid     = (state_q == S_PUBLISH);
   assign busy         = (state_q != S_IDLE);
   assign missedFrames = missed_q;
   assign leftPaddle   = pub_q[0];
   assign rightPaddle  = pub_q[1];
   assign ballPos      = pub_q[2];

endmodule

// File: tb/tb_paddle_position_reader.sv
// Bench for paddle_position_reader: three instances (read latency 1, 3, 4),
// each fed by a small DPRAM model that honours its latency.
module tb_paddle_position_reader;

   localparam int N_DUT = 3;
   localparam logic [31:0] RST_L = {16'h000F, 16'd190};
   localparam logic [31:0] RST_R = {16'd615, 16'd190};
   localparam logic [31:0] RST_B = {16'd320, 16'd240};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fs        [N_DUT];
   logic        rd_en     [N_DUT];
   logic [15:0] rd_addr   [N_DUT];
   logic [31:0] left_pos  [N_DUT];
   logic [31:0] right_pos [N_DUT];
   logic [31:0] ball_pos  [N_DUT];
   logic        pos_valid [N_DUT];
   logic        busy      [N_DUT];
   logic [7:0]  missed    [N_DUT];
   logic [31:0] mem       [4];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
      logic [31:0] dout = '0;
      logic [3:0]  en_h = '0;
      logic [15:0] a_h [3];
      logic [3:0]  en_all;
      logic [15:0] a_all [4];

      // Bit k of en_all / entry k of a_all is the read request issued k cycles ago.
      always_comb begin
         en_all   = {en_h[2:0], rd_en[g]};
         a_all[0] = rd_addr[g];
         for (int k = 1; k < 4; k++) a_all[k] = a_h[k-1];
      end

      always @(posedge clk) begin
         en_h <= en_all;
         for (int k = 0; k < 3; k++) a_h[k] <= a_all[k];
         if (en_all[LAT-1]) dout <= mem[a_all[LAT-1][1:0]];
      end

      paddle_position_reader #(.RD_LATENCY(LAT)) u_dut (
         .clk          (clk),
         .rst          (rst),
         .frameStart   (fs[g]),
         .rdEnable     (rd_en[g]),
         .rdAddr       (rd_addr[g]),
         .rdData       (dout),
         .leftPaddle   (left_pos[g]),
         .rightPaddle  (right_pos[g]),
         .ballPos      (ball_pos[g]),
         .posValid     (pos_valid[g]),
         .busy         (busy[g]),
         .missedFrames (missed[g])
      );
   end

   typedef struct {
      logic [31:0] w0, w1, w2;
      logic [31:0] el, er, eb;
   } vec_t;

   vec_t vecs [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic load_mem(input vec_t v);
      mem[0] = v.w0;
      mem[1] = v.w1;
      mem[2] = v.w2;
      mem[3] = 32'hDEAD_BEEF;
   endtask

   // Pulses frameStart for one cycle, then watches the fetch for up to 60 cycles.
   task automatic run_fetch(input int sel, input int exp_lat, input vec_t v, input string tag);
      int lat;
      int pulses;
      logic addr_ok;
      tick();
      fs[sel] = 1'b1;
      tick();
      fs[sel] = 1'b0;
      lat     = -1;
      pulses  = 0;
      addr_ok = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         if (rd_en[sel]) begin
            if (rd_addr[sel] != 16'(pulses)) addr_ok = 1'b0;
            pulses++;
         end
         if (pos_valid[sel]) begin
            lat = k;
            break;
         end
         tick();
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_rd_pulses"}, pulses, 3);
      check({tag, "_rd_addrs"}, 32'(addr_ok), 32'd1);
      tick();
      check({tag, "_pv_one_cycle"}, 32'(pos_valid[sel]), 32'd0);
      check({tag, "_busy_after"}, 32'(busy[sel]), 32'd0);
      check({tag, "_left"}, left_pos[sel], v.el);
      check({tag, "_right"}, right_pos[sel], v.er);
      check({tag, "_ball"}, ball_pos[sel], v.eb);
   endtask

   initial begin
      int pv_cnt, first_pv, second_pv, en_cnt, busy_cycles;
      logic busy_k12;

      vecs[0] = '{32'h000F_0064, 32'h0267_00C8, 32'h0140_00F0,
                  32'h000F_0064, 32'h0267_00C8, 32'h0140_00F0};
      vecs[1] = '{32'h000F_0190, 32'h0267_00C8, 32'h0140_01F4,
                  32'h000F_017C, 32'h0267_00C8, 32'h0140_01DF};
      vecs[2] = '{32'h1234_017C, 32'hABCD_017D, 32'hFFFF_01DF,
                  32'h1234_017C, 32'hABCD_017C, 32'hFFFF_01DF};
      vecs[3] = '{32'h0000_FFFF, 32'h8000_0000, 32'h7FFF_01E0,
                  32'h0000_017C, 32'h8000_0000, 32'h7FFF_01DF};

      for (int i = 0; i < N_DUT; i++) fs[i] = 1'b0;
      load_mem(vecs[0]);
      #2 rst = 1'b0;
      repeat (3) tick();

      check("reset_rd_enable", 32'(rd_en[0]), 32'd0);
      check("reset_rd_addr", 32'(rd_addr[0]), 32'd0);
      check("reset_pos_valid", 32'(pos_valid[0]), 32'd0);
      check("reset_busy", 32'(busy[0]), 32'd0);
      check("reset_missed", 32'(missed[0]), 32'd0);
      check("reset_left", left_pos[0], RST_L);
      check("reset_right", right_pos[0], RST_R);
      check("reset_ball", ball_pos[0], RST_B);

      rst = 1'b1;
      repeat (2) tick();

      for (int v = 0; v < 4; v++) begin
         load_mem(vecs[v]);
         run_fetch(0, 10, vecs[v], $sformatf("vec%0d", v));
      end

      load_mem(vecs[0]);
      run_fetch(1, 16, vecs[0], "lat3");

      // Overrun: second pulse 3 cycles in is dropped; a pulse in the IDLE cycle
      // right after PUBLISH starts a new fetch.
      load_mem(vecs[1]);
      pv_cnt    = 0;
      first_pv  = -1;
      second_pv = -1;
      en_cnt    = 0;
      busy_k12  = 1'b0;
      tick();
      fs[0] = 1'b1;
      tick();
      for (int k = 1; k <= 40; k++) begin
         if (pos_valid[0]) begin
            pv_cnt++;
            if (first_pv < 0) first_pv = k;
            else if (second_pv < 0) second_pv = k;
         end
         if (rd_en[0]) en_cnt++;
         if (k == 12) busy_k12 = busy[0];
         fs[0] = (k == 3) || (k == 11);
         tick();
      end
      fs[0] = 1'b0;
      check("overrun_pv_count", pv_cnt, 2);
      check("overrun_first_pv", first_pv, 10);
      check("overrun_second_pv", second_pv, 21);
      check("overrun_rd_pulses", en_cnt, 6);
      check("overrun_accept_after_publish", 32'(busy_k12), 32'd1);
      check("overrun_missed", 32'(missed[0]), 32'd1);
      check("overrun_left", left_pos[0], vecs[1].el);
      check("overrun_right", right_pos[0], vecs[1].er);
      check("overrun_ball", ball_pos[0], vecs[1].eb);

      // Saturation on the latency-4 instance: frameStart held high, one frame
      // every 20 cycles, 19 of which drop the request.
      tick();
      fs[2] = 1'b1;
      repeat (40) tick();
      check("sat_missed_two_frames", 32'(missed[2]), 32'd38);
      repeat (360) tick();
      fs[2] = 1'b0;
      repeat (25) tick();
      check("sat_missed_255", 32'(missed[2]), 32'd255);
      check("sat_busy_idle", 32'(busy[2]), 32'd0);

      // Reset abort during WAIT of entry 1.
      load_mem(vecs[2]);
      tick();
      fs[0] = 1'b1;
      tick();
      fs[0] = 1'b0;
      repeat (4) tick();
      check("abort_busy_before", 32'(busy[0]), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("abort_busy", 32'(busy[0]), 32'd0);
      check("abort_rd_enable", 32'(rd_en[0]), 32'd0);
      check("abort_rd_addr", 32'(rd_addr[0]), 32'd0);
      check("abort_pos_valid", 32'(pos_valid[0]), 32'd0);
      check("abort_missed", 32'(missed[0]), 32'd0);
      check("abort_left", left_pos[0], RST_L);
      check("abort_right", right_pos[0], RST_R);
      check("abort_ball", ball_pos[0], RST_B);

      // frameStart coincident with the reset-release edge must be ignored.
      tick();
      fs[0] = 1'b1;
      @(posedge clk);
      rst = 1'b1;
      #1;
      fs[0] = 1'b0;
      pv_cnt      = 0;
      busy_cycles = 0;
      for (int k = 0; k < 15; k++) begin
         if (pos_valid[0]) pv_cnt++;
         if (busy[0]) busy_cycles++;
         tick();
      end
      check("release_no_pv", pv_cnt, 0);
      check("release_no_fetch", busy_cycles, 0);
      check("release_left", left_pos[0], RST_L);

      run_fetch(0, 10, vecs[2], "post_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
